uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 191 +++++++++++++++++++
 tb/tb_uart_rx.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver with a one-deep valid/ready output register.
//
// Decodes frames of 1 start bit, 8 data bits (LSB first) and 1 stop bit from
// the serial line. The bit period is CLKS_PER_BIT clock cycles. A completed
// byte is loaded into the output register. If the previous byte is still
// unaccepted, the new byte is dropped and overrun_o pulses. A low stop bit
// pulses frame_err_o. The receiver then waits for the line to return high.
//
// Build option (macro UART_RX_SYNC_EN):
//   defined   : uart_i passes through a two-flop synchronizer (asynchronous line)
//   undefined : uart_i passes through a single input register (same-domain loopback)
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous, active-high reset
//   uart_i       in   serial line, idles high
//   uart_data_o  out  received byte, stable while valid_o is high
//   valid_o      out  byte available, held until accepted
//   ready_i      in   consumer accepts the byte when valid_o && ready_i
//   frame_err_o  out  one-cycle pulse: stop bit sampled low
//   overrun_o    out  one-cycle pulse: a completed byte was dropped
module uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_i,
   output logic [7:0] uart_data_o,
   output logic       valid_o,
   input  logic       ready_i,
   output logic       frame_err_o,
   output logic       overrun_o
);

   // Offset from the start-bit detection to the mid-bit sample point.
   localparam int unsigned M        = (CLKS_PER_BIT - 1) / 2;
   localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] MID_LAST = (M > 0) ? 16'(M - 1) : 16'd0;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } state_t;

   state_t      state, state_n;
   logic [15:0] cnt, cnt_n;
   logic [2:0]  bit_idx, bit_idx_n;
   logic [7:0]  shift_q, shift_n;
   logic        byte_done;
   logic        frame_err_n;
   logic        rx_s;

   // Input conditioning; every stage resets to the idle (high) level.
`ifdef UART_RX_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[0], uart_i};
      end
   end

   assign rx_s = sync_q[1];
`else
   logic sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= 1'b1;
      end else begin
         sync_q <= uart_i;
      end
   end

   assign rx_s = sync_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift_q <= '0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         bit_idx <= bit_idx_n;
         shift_q <= shift_n;
      end
   end

   // cnt restarts at every sample point. Each state then waits for its own
   // distance to the next sample. With M = 0 the start-bit sample coincides
   // with detection, so IDLE goes straight to DATA.
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      bit_idx_n   = bit_idx;
      shift_n     = shift_q;
      byte_done   = 1'b0;
      frame_err_n = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_s) begin
               cnt_n     = '0;
               bit_idx_n = '0;
               if (M == 0) begin
                  state_n = DATA;
               end else begin
                  state_n = START;
               end
            end
         end
         START: begin
            if (cnt == MID_LAST) begin
               cnt_n     = '0;
               bit_idx_n = '0;
               state_n   = rx_s ? IDLE : DATA;
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_n   = '0;
               shift_n = {rx_s, shift_q[7:1]};
               if (bit_idx == 3'd7) begin
                  state_n = STOP;
               end else begin
                  bit_idx_n = bit_idx + 3'd1;
               end
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         STOP: begin
            if (cnt == BIT_LAST) begin
               cnt_n     = '0;
               bit_idx_n = '0;
               if (rx_s) begin
                  byte_done = 1'b1;
                  state_n   = IDLE;
               end else begin
                  frame_err_n = 1'b1;
                  state_n     = WAIT_IDLE;
               end
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         WAIT_IDLE: begin
            if (rx_s) begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Output register. All outputs are registered, so ready_i never reaches
   // an output combinationally.
   always_ff @(posedge clk) begin
      if (rst) begin
         uart_data_o <= '0;
         valid_o     <= 1'b0;
         frame_err_o <= 1'b0;
         overrun_o   <= 1'b0;
      end else begin
         frame_err_o <= frame_err_n;
         overrun_o   <= 1'b0;
         if (byte_done) begin
            if (!valid_o || ready_i) begin
               uart_data_o <= shift_q;
               valid_o     <= 1'b1;
            end else begin
               overrun_o <= 1'b1;
            end
         end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- directed self-checking bench for uart_rx.
// Instance "a" uses CLKS_PER_BIT=2 and instance "b" uses CLKS_PER_BIT=16.
// The bench generates the serial frames itself, acting as a uart_tx model.
module tb_uart_rx;

`ifdef UART_RX_SYNC_EN
   localparam int S = 2;
`else
   localparam int S = 1;
`endif
   localparam int C2    = 2;
   localparam int C16   = 16;
   // uart_i fall to valid_o rise: M + 9*C + 1 + S
   localparam int LAT2  = 19 + S;   // M=0, C=2
   localparam int LAT16 = 152 + S;  // M=7, C=16

   logic       clk;
   logic       rst;
   logic       uart_a, ready_a, valid_a, ferr_a, ovr_a;
   logic [7:0] data_a;
   logic       uart_b, ready_b, valid_b, ferr_b, ovr_b;
   logic [7:0] data_b;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   uart_rx #(.CLKS_PER_BIT(C2)) dut_a (
      .clk(clk), .rst(rst), .uart_i(uart_a), .uart_data_o(data_a),
      .valid_o(valid_a), .ready_i(ready_a), .frame_err_o(ferr_a), .overrun_o(ovr_a)
   );

   uart_rx #(.CLKS_PER_BIT(C16)) dut_b (
      .clk(clk), .rst(rst), .uart_i(uart_b), .uart_data_o(data_b),
      .valid_o(valid_b), .ready_i(ready_b), .frame_err_o(ferr_b), .overrun_o(ovr_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Event log, sampled mid-cycle.
   logic       valid_a_d = 1'b0;
   logic       valid_b_d = 1'b0;
   int         vhi_a     = 0;
   int         rise_a_cyc[$];
   logic [7:0] rise_a_dat[$];
   int         ferr_a_q[$];
   int         ovr_a_q[$];
   int         rise_b_cyc[$];
   logic [7:0] rise_b_dat[$];
   int         ferr_b_q[$];

   always @(negedge clk) begin
      if (valid_a === 1'b1 && valid_a_d !== 1'b1) begin
         rise_a_cyc.push_back(cyc);
         rise_a_dat.push_back(data_a);
      end
      if (valid_a === 1'b1) vhi_a = vhi_a + 1;
      if (ferr_a === 1'b1) ferr_a_q.push_back(cyc);
      if (ovr_a === 1'b1) ovr_a_q.push_back(cyc);
      if (valid_b === 1'b1 && valid_b_d !== 1'b1) begin
         rise_b_cyc.push_back(cyc);
         rise_b_dat.push_back(data_b);
      end
      if (ferr_b === 1'b1) ferr_b_q.push_back(cyc);
      valid_a_d = valid_a;
      valid_b_d = valid_b;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input int sel, input logic v, input int n);
      if (sel == 0) uart_a = v;
      else uart_b = v;
      tick(n);
   endtask

   // One frame; leaves the line at the stop-bit level. fall = cycle of start edge.
   task automatic send(input int sel, input logic [7:0] b, input logic stop, output int fall);
      int c;
      c = (sel == 0) ? C2 : C16;
      fall = cyc;
      drive(sel, 1'b0, c);
      for (int k = 0; k < 8; k++) drive(sel, b[k], c);
      drive(sel, stop, c);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick(3);
      @(negedge clk);
      if (data_a !== 8'h00) begin $display("FAIL reset_data: got %h want 00", data_a); n_err++; end
      n_cmp++;
      if (valid_a !== 1'b0) begin $display("FAIL reset_valid: got %b want 0", valid_a); n_err++; end
      n_cmp++;
      if (ferr_a !== 1'b0) begin $display("FAIL reset_ferr: got %b want 0", ferr_a); n_err++; end
      n_cmp++;
      if (ovr_a !== 1'b0) begin $display("FAIL reset_ovr: got %b want 0", ovr_a); n_err++; end
      n_cmp++;
      if (valid_b !== 1'b0) begin $display("FAIL reset_valid_b: got %b want 0", valid_b); n_err++; end
      n_cmp++;
      @(posedge clk);
      #1 rst = 1'b0;
      tick(3);
   endtask

   task automatic test_single;
      int f, r0, e0, o0, v0;
      r0 = rise_a_cyc.size(); e0 = ferr_a_q.size(); o0 = ovr_a_q.size(); v0 = vhi_a;
      send(0, 8'hA5, 1'b1, f);
      tick(6);
      @(negedge clk);
      if (rise_a_cyc.size() - r0 !== 1) begin
         $display("FAIL single_count: got %0d want 1", rise_a_cyc.size() - r0); n_err++;
      end
      n_cmp++;
      if (rise_a_cyc.size() > r0) begin
         if (rise_a_dat[r0] !== 8'hA5) begin $display("FAIL single_data: got %h want a5", rise_a_dat[r0]); n_err++; end
         n_cmp++;
         if (rise_a_cyc[r0] - f !== LAT2) begin
            $display("FAIL single_latency: got %0d want %0d", rise_a_cyc[r0] - f, LAT2); n_err++;
         end
         n_cmp++;
      end
      if (vhi_a - v0 !== 1) begin $display("FAIL single_width: got %0d want 1", vhi_a - v0); n_err++; end
      n_cmp++;
      if (ferr_a_q.size() - e0 !== 0 || ovr_a_q.size() - o0 !== 0) begin
         $display("FAIL single_flags: got ferr %0d ovr %0d want 0 0", ferr_a_q.size() - e0, ovr_a_q.size() - o0);
         n_err++;
      end
      n_cmp++;
   endtask

   task automatic test_back_to_back;
      int f1, f2, r0, e0;
      r0 = rise_a_cyc.size(); e0 = ferr_a_q.size();
      send(0, 8'h00, 1'b1, f1);
      send(0, 8'hFF, 1'b1, f2);
      tick(6);
      @(negedge clk);
      if (rise_a_cyc.size() - r0 !== 2) begin
         $display("FAIL b2b_count: got %0d want 2", rise_a_cyc.size() - r0); n_err++;
      end
      n_cmp++;
      if (rise_a_cyc.size() - r0 >= 2) begin
         if (rise_a_dat[r0] !== 8'h00) begin $display("FAIL b2b_data0: got %h want 00", rise_a_dat[r0]); n_err++; end
         n_cmp++;
         if (rise_a_dat[r0+1] !== 8'hFF) begin $display("FAIL b2b_data1: got %h want ff", rise_a_dat[r0+1]); n_err++; end
         n_cmp++;
         if (rise_a_cyc[r0+1] - rise_a_cyc[r0] !== 20) begin
            $display("FAIL b2b_spacing: got %0d want 20", rise_a_cyc[r0+1] - rise_a_cyc[r0]); n_err++;
         end
         n_cmp++;
      end
      if (ferr_a_q.size() - e0 !== 0) begin $display("FAIL b2b_ferr: got %0d want 0", ferr_a_q.size() - e0); n_err++; end
      n_cmp++;
   endtask

   task automatic test_glitch;
      int f, r0, e0;
      r0 = rise_b_cyc.size(); e0 = ferr_b_q.size();
      drive(1, 1'b0, 3);
      drive(1, 1'b1, 40);
      @(negedge clk);
      if (rise_b_cyc.size() - r0 !== 0) begin $display("FAIL glitch_valid: got %0d want 0", rise_b_cyc.size() - r0); n_err++; end
      n_cmp++;
      if (ferr_b_q.size() - e0 !== 0) begin $display("FAIL glitch_ferr: got %0d want 0", ferr_b_q.size() - e0); n_err++; end
      n_cmp++;
      send(1, 8'h96, 1'b1, f);
      tick(10);
      @(negedge clk);
      if (rise_b_cyc.size() - r0 !== 1) begin
         $display("FAIL glitch_after_count: got %0d want 1", rise_b_cyc.size() - r0); n_err++;
      end
      n_cmp++;
      if (rise_b_cyc.size() > r0) begin
         if (rise_b_dat[r0] !== 8'h96) begin $display("FAIL glitch_after_data: got %h want 96", rise_b_dat[r0]); n_err++; end
         n_cmp++;
         if (rise_b_cyc[r0] - f !== LAT16) begin
            $display("FAIL glitch_after_latency: got %0d want %0d", rise_b_cyc[r0] - f, LAT16); n_err++;
         end
         n_cmp++;
      end
   endtask

   task automatic test_frame_err;
      int f1, f2, r0, e0;
      r0 = rise_a_cyc.size(); e0 = ferr_a_q.size();
      send(0, 8'h3C, 1'b0, f1);
      drive(0, 1'b0, 40);
      drive(0, 1'b1, 4);
      send(0, 8'h11, 1'b1, f2);
      tick(6);
      @(negedge clk);
      if (ferr_a_q.size() - e0 !== 1) begin $display("FAIL ferr_count: got %0d want 1", ferr_a_q.size() - e0); n_err++; end
      n_cmp++;
      if (ferr_a_q.size() > e0) begin
         if (ferr_a_q[e0] - f1 !== LAT2) begin
            $display("FAIL ferr_timing: got %0d want %0d", ferr_a_q[e0] - f1, LAT2); n_err++;
         end
         n_cmp++;
      end
      if (rise_a_cyc.size() - r0 !== 1) begin $display("FAIL ferr_valid_count: got %0d want 1", rise_a_cyc.size() - r0); n_err++; end
      n_cmp++;
      if (rise_a_cyc.size() > r0) begin
         if (rise_a_dat[r0] !== 8'h11) begin $display("FAIL ferr_next_data: got %h want 11", rise_a_dat[r0]); n_err++; end
         n_cmp++;
         if (rise_a_cyc[r0] - f2 !== LAT2) begin
            $display("FAIL ferr_next_latency: got %0d want %0d", rise_a_cyc[r0] - f2, LAT2); n_err++;
         end
         n_cmp++;
      end
   endtask

   task automatic test_overrun;
      int f1, f2, r0, o0;
      r0 = rise_a_cyc.size(); o0 = ovr_a_q.size();
      ready_a = 1'b0;
      send(0, 8'h12, 1'b1, f1);
      send(0, 8'h34, 1'b1, f2);
      tick(6);
      @(negedge clk);
      if (valid_a !== 1'b1) begin $display("FAIL ovr_valid_held: got %b want 1", valid_a); n_err++; end
      n_cmp++;
      if (data_a !== 8'h12) begin $display("FAIL ovr_data_held: got %h want 12", data_a); n_err++; end
      n_cmp++;
      if (ovr_a_q.size() - o0 !== 1) begin $display("FAIL ovr_count: got %0d want 1", ovr_a_q.size() - o0); n_err++; end
      n_cmp++;
      if (ovr_a_q.size() > o0) begin
         if (ovr_a_q[o0] - f2 !== LAT2) begin
            $display("FAIL ovr_timing: got %0d want %0d", ovr_a_q[o0] - f2, LAT2); n_err++;
         end
         n_cmp++;
      end
      @(posedge clk);
      #1 ready_a = 1'b1;
      tick(1);
      ready_a = 1'b0;
      @(negedge clk);
      if (valid_a !== 1'b0) begin $display("FAIL ovr_accept_drop: got %b want 0", valid_a); n_err++; end
      n_cmp++;
      tick(30);
      @(negedge clk);
      if (rise_a_cyc.size() - r0 !== 1) begin
         $display("FAIL ovr_dropped_never_shown: got %0d rises want 1", rise_a_cyc.size() - r0); n_err++;
      end
      n_cmp++;
      if (ovr_a_q.size() - o0 !== 1) begin $display("FAIL ovr_count_final: got %0d want 1", ovr_a_q.size() - o0); n_err++; end
      n_cmp++;
      ready_a = 1'b1;
   endtask

   task automatic test_reset_mid;
      int f, r0, e0;
      logic [7:0] b;
      ready_a = 1'b0;
      send(0, 8'hC3, 1'b1, f);
      tick(4);
      @(negedge clk);
      if (valid_a !== 1'b1 || data_a !== 8'hC3) begin
         $display("FAIL rstmid_pending: got %b/%h want 1/c3", valid_a, data_a); n_err++;
      end
      n_cmp++;
      @(posedge clk);
      #1;
      b = 8'h77;
      drive(0, 1'b0, C2);
      for (int k = 0; k < 4; k++) drive(0, b[k], C2);
      drive(0, b[4], 1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      uart_a = 1'b1;
      @(negedge clk);
      if (valid_a !== 1'b0 || data_a !== 8'h00 || ferr_a !== 1'b0 || ovr_a !== 1'b0) begin
         $display("FAIL rstmid_outputs: got v%b d%h e%b o%b want v0 d00 e0 o0", valid_a, data_a, ferr_a, ovr_a);
         n_err++;
      end
      n_cmp++;
      r0 = rise_a_cyc.size(); e0 = ferr_a_q.size();
      tick(30);
      @(negedge clk);
      if (rise_a_cyc.size() - r0 !== 0 || ferr_a_q.size() - e0 !== 0) begin
         $display("FAIL rstmid_aborted: got rises %0d ferr %0d want 0 0", rise_a_cyc.size() - r0, ferr_a_q.size() - e0);
         n_err++;
      end
      n_cmp++;
      ready_a = 1'b1;
      @(posedge clk);
      #1;
      send(0, 8'h5A, 1'b1, f);
      tick(6);
      @(negedge clk);
      if (rise_a_cyc.size() - r0 !== 1) begin $display("FAIL rstmid_next_count: got %0d want 1", rise_a_cyc.size() - r0); n_err++; end
      n_cmp++;
      if (rise_a_cyc.size() > r0) begin
         if (rise_a_dat[r0] !== 8'h5A) begin $display("FAIL rstmid_next_data: got %h want 5a", rise_a_dat[r0]); n_err++; end
         n_cmp++;
      end
   endtask

   initial begin
      rst     = 1'b1;
      uart_a  = 1'b1;
      uart_b  = 1'b1;
      ready_a = 1'b1;
      ready_b = 1'b1;
      test_reset;
      test_single;
      test_back_to_back;
      test_glitch;
      test_frame_err;
      test_overrun;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
